// File: rtl/array_seq_ctrl.sv
// rtl/array_seq_ctrl.sv - bit-serial register-file sequencer for the PE array (optional host load port: ARRAY_SEQ_LOAD_EN)
module array_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter int NREG   = 32,
    parameter int PE_N   = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        alu_op,
    output logic              first_bit,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic              wea,
    output logic              web,
    output logic [PE_N-1:0]   dia,
    output logic              east,
    output logic              west,
    output logic              south,
    output logic              north,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [PE_N-1:0]   load_data
);
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [20:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [PE_N-1:0]   dia_q, dia_d;
    logic [3:0]        alu_op_q, alu_op_d, dir_q, dir_d;
    logic              wea_q, wea_d, web_q, web_d, first_bit_q, first_bit_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [20:0] ins;
    logic [5:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic        is_alu, is_shift, illegal, load_fire, go_read;
    logic [3:0]  dir_sel;
    int          step, k_cur, k_nxt;
    logic        unused_instr;

    assign unused_instr = ^instr[10:0];

    function automatic logic [ADDR_W-1:0] bit_addr(input logic [4:0] r, input int k);
        return ADDR_W'(int'(r) * WIDTH + k);
    endfunction

    assign instr_ready = reset && (state_q == S_IDLE);
`ifdef ARRAY_SEQ_LOAD_EN
    assign load_ready  = reset && (state_q == S_IDLE) && !instr_valid;
    assign load_fire   = load_valid && load_ready;
`else
    logic unused_load;
    assign unused_load = ^{load_valid, load_addr, load_data};
    assign load_ready  = 1'b0;
    assign load_fire   = 1'b0;
`endif

    // Decode the incoming instruction while idle, the latched one otherwise
    always_comb begin
        ins      = (state_q == S_IDLE) ? instr[31:11] : instr_q;
        opc      = ins[20:15];
        rd       = ins[14:10];
        rs1      = ins[9:5];
        rs2      = ins[4:0];
        is_alu   = (opc <= 6'd4) || (opc == 6'd9);
        is_shift = (opc >= 6'd5) && (opc <= 6'd8);
        illegal  = !(is_alu || is_shift) || (int'(rd) >= NREG) || (int'(rs1) >= NREG)
                   || ((opc <= 6'd4) && (int'(rs2) >= NREG));
        dir_sel  = 4'b0000;
        case (opc)
            6'd5:    dir_sel = 4'b1000;
            6'd6:    dir_sel = 4'b0100;
            6'd7:    dir_sel = 4'b0010;
            6'd8:    dir_sel = 4'b0001;
            default: dir_sel = 4'b0000;
        endcase
    end

    // Next state and next registered outputs; outputs describe the state being entered
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        instr_d     = instr_q;
        alu_op_d    = alu_op_q;
        addra_d     = '0;
        addrb_d     = '0;
        dia_d       = '0;
        wea_d       = 1'b0;
        web_d       = 1'b0;
        first_bit_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dir_d       = 4'b0000;
        go_read     = 1'b0;
        step        = is_shift ? 2 : 1;
        k_cur       = int'(k_q);
        k_nxt       = k_cur;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d  = ins;
                    alu_op_d = opc[3:0];
                    if (illegal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        go_read = 1'b1;
                        k_nxt   = 0;
                    end
                end else if (load_fire) begin
`ifdef ARRAY_SEQ_LOAD_EN
                    wea_d   = 1'b1;
                    addra_d = load_addr;
                    dia_d   = load_data;
`endif
                end
            end
            S_READ: begin
                state_d = S_WRITE;
                busy_d  = 1'b1;
                dir_d   = dir_sel;
                wea_d   = 1'b1;
                addra_d = bit_addr(rd, k_cur);
                if (is_shift) begin
                    web_d   = 1'b1;
                    addrb_d = bit_addr(rd, k_cur + 1);
                end
            end
            S_WRITE: begin
                if (k_cur >= WIDTH - step) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    go_read = 1'b1;
                    k_nxt   = k_cur + step;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_read) begin
            state_d     = S_READ;
            busy_d      = 1'b1;
            k_d         = KW'(k_nxt);
            dir_d       = dir_sel;
            addra_d     = bit_addr(rs1, k_nxt);
            addrb_d     = is_shift ? bit_addr(rs1, k_nxt + 1) : bit_addr(rs2, k_nxt);
            first_bit_d = is_alu && (k_nxt == 0);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            instr_q     <= '0;
            alu_op_q    <= '0;
            addra_q     <= '0;
            addrb_q     <= '0;
            dia_q       <= '0;
            wea_q       <= 1'b0;
            web_q       <= 1'b0;
            first_bit_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dir_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            instr_q     <= instr_d;
            alu_op_q    <= alu_op_d;
            addra_q     <= addra_d;
            addrb_q     <= addrb_d;
            dia_q       <= dia_d;
            wea_q       <= wea_d;
            web_q       <= web_d;
            first_bit_q <= first_bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dir_q       <= dir_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign alu_op    = alu_op_q;
    assign first_bit = first_bit_q;
    assign addra     = addra_q;
    assign addrb     = addrb_q;
    assign wea       = wea_q;
    assign web       = web_q;
    assign dia       = dia_q;
    assign east      = dir_q[3];
    assign west      = dir_q[2];
    assign south     = dir_q[1];
    assign north     = dir_q[0];
endmodule

// File: tb/tb_array_seq_ctrl.sv
// tb/tb_array_seq_ctrl.sv - self-checking bench for array_seq_ctrl against a trace-level model
module tb_array_seq_ctrl;
    localparam int WIDTH  = 32;
    localparam int NREG   = 8;
    localparam int PE_N   = 16;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [31:0]       instr = '0;
    logic              busy, done, err, first_bit, wea, web;
    logic              east, west, south, north;
    logic [3:0]        alu_op;
    logic [ADDR_W-1:0] addra, addrb;
    logic [PE_N-1:0]   dia;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [PE_N-1:0]   load_data = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addra;
        logic [ADDR_W-1:0] addrb;
        logic              wea;
        logic              web;
        logic              first_bit;
        logic              busy;
        logic              done;
        logic              err;
        logic [3:0]        dir;
    } obs_t;

    obs_t exp_q[$];

    array_seq_ctrl #(.WIDTH(WIDTH), .NREG(NREG), .PE_N(PE_N), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .busy(busy), .done(done), .err(err), .alu_op(alu_op),
        .first_bit(first_bit), .addra(addra), .addrb(addrb), .wea(wea), .web(web),
        .dia(dia), .east(east), .west(west), .south(south), .north(north),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2);
        return {op, rd, r1, r2, 11'h0};
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.addra = addra; o.addrb = addrb; o.wea = wea; o.web = web;
        o.first_bit = first_bit; o.busy = busy; o.done = done; o.err = err;
        o.dir = {east, west, south, north};
        return o;
    endfunction

    // Expected per-cycle outputs from cycle 1 up to and including the done cycle
    task automatic build(input logic [31:0] ins);
        int op, rd, r1, r2;
        bit alu, shf, bad;
        obs_t e;
        op = int'(ins[31:26]); rd = int'(ins[25:21]); r1 = int'(ins[20:16]); r2 = int'(ins[15:11]);
        alu = (op <= 4) || (op == 9);
        shf = (op >= 5) && (op <= 8);
        bad = !(alu || shf) || rd >= NREG || r1 >= NREG || (op <= 4 && r2 >= NREG);
        exp_q.delete();
        if (!bad && alu) begin
            for (int k = 0; k < WIDTH; k++) begin
                e = '0; e.busy = 1'b1; e.first_bit = (k == 0);
                e.addra = ADDR_W'(r1 * WIDTH + k); e.addrb = ADDR_W'(r2 * WIDTH + k);
                exp_q.push_back(e);
                e = '0; e.busy = 1'b1; e.wea = 1'b1; e.addra = ADDR_W'(rd * WIDTH + k);
                exp_q.push_back(e);
            end
        end else if (!bad && shf) begin
            for (int k = 0; k < WIDTH; k += 2) begin
                e = '0; e.busy = 1'b1; e.dir = 4'b1000 >> (op - 5);
                e.addra = ADDR_W'(r1 * WIDTH + k); e.addrb = ADDR_W'(r1 * WIDTH + k + 1);
                exp_q.push_back(e);
                e.wea = 1'b1; e.web = 1'b1;
                e.addra = ADDR_W'(rd * WIDTH + k); e.addrb = ADDR_W'(rd * WIDTH + k + 1);
                exp_q.push_back(e);
            end
        end
        e = '0; e.done = 1'b1; e.err = bad;
        exp_q.push_back(e);
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit with_load, output int done_cyc);
        obs_t o;
        build(ins);
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        load_valid = with_load; load_addr = 10'd7; load_data = 16'h1234;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready got=%b exp=1", instr_ready);
        end
        if (with_load) begin
            checks++;
            if (load_ready !== 1'b0) begin
                errors++; $display("FAIL load_ready_vs_instr got=%b exp=0", load_ready);
            end
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0; load_valid = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < exp_q.size(); c++) begin
            o = sample();
            checks++;
            if (o !== exp_q[c]) begin
                errors++;
                $display("FAIL trace op=%0d cycle=%0d got=%h exp=%h", ins[31:26], c + 1, o, exp_q[c]);
            end
            if (c == 0) begin
                checks++;
                if (alu_op !== ins[29:26]) begin
                    errors++; $display("FAIL alu_op got=%0d exp=%0d", alu_op, ins[29:26]);
                end
            end
            if (o.done === 1'b1 && done_cyc < 0) done_cyc = c + 1;
            @(negedge clk);
        end
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL return_idle got ready=%b busy=%b done=%b exp 1,0,0", instr_ready, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; instr_valid = 1'b1; instr = mk(6'd0, 5'd2, 5'd0, 5'd1);
        load_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, err, wea, web, first_bit, east, west, south, north} !== 10'b0
            || addra !== '0 || addrb !== '0 || alu_op !== '0 || dia !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b wea=%b addra=%0d exp all zero",
                               busy, done, wea, addra);
        end
        checks++;
        if (instr_ready !== 1'b0 || load_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b%b exp=00", instr_ready, load_ready);
        end
        instr_valid = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int dc;
        run_instr(mk(6'd0, 5'd2, 5'd0, 5'd1), 1'b0, dc);
        checks++;
        if (dc != 2 * WIDTH + 1) begin
            errors++; $display("FAIL add_latency got=%0d exp=%0d", dc, 2 * WIDTH + 1);
        end
    endtask

    task automatic test_east();
        int dc;
        run_instr(mk(6'd5, 5'd3, 5'd3, 5'd0), 1'b0, dc);
        checks++;
        if (dc != WIDTH + 1) begin
            errors++; $display("FAIL east_latency got=%0d exp=%0d", dc, WIDTH + 1);
        end
    endtask

    task automatic test_illegal();
        int dc;
        run_instr(mk(6'd12, 5'd1, 5'd1, 5'd1), 1'b0, dc);
        checks++;
        if (dc != 1) begin
            errors++; $display("FAIL illegal_op_latency got=%0d exp=1", dc);
        end
        run_instr(mk(6'd0, 5'd1, 5'(NREG), 5'd1), 1'b0, dc);
        checks++;
        if (dc != 1) begin
            errors++; $display("FAIL illegal_reg_latency got=%0d exp=1", dc);
        end
    endtask

    task automatic test_random();
        int dc, op, exp_dc;
        logic [31:0] ins;
        for (int n = 0; n < 24; n++) begin
            op  = int'($urandom_range(0, 15));
            ins = mk(6'(op), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
            run_instr(ins, 1'b0, dc);
            exp_dc = exp_q.size();
            checks++;
            if (dc != exp_dc) begin
                errors++; $display("FAIL random_latency op=%0d got=%0d exp=%0d", op, dc, exp_dc);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        instr = mk(6'd0, 5'd2, 5'd0, 5'd1); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (wea !== 1'b1) begin
            errors++; $display("FAIL mid_write_before_reset got wea=%b exp=1", wea);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (wea !== 1'b0 || busy !== 1'b0 || addra !== '0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_reset got wea=%b busy=%b addra=%0d done=%b exp 0,0,0,0",
                               wea, busy, addra, done);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_release got ready=%b done=%b exp 1,0", instr_ready, done);
        end
    endtask

    task automatic test_load();
        logic              en;
        logic [ADDR_W-1:0] pa;
        logic [PE_N-1:0]   pd;
        int dc;
`ifdef ARRAY_SEQ_LOAD_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (wea !== en || addra !== (en ? pa : '0) || dia !== (en ? pd : '0)) begin
                    errors++; $display("FAIL load_write i=%0d got wea=%b addra=%0d dia=%h exp wea=%b addra=%0d dia=%h",
                                       i, wea, addra, dia, en, en ? pa : '0, en ? pd : '0);
                end
            end
            if (i < 4) begin
                pa = (i == 0) ? 10'd5 : ADDR_W'($urandom_range(0, 1023));
                pd = (i == 0) ? 16'h2000 : PE_N'($urandom_range(0, 65535));
                load_valid = 1'b1; load_addr = pa; load_data = pd; instr_valid = 1'b0;
                #1;
                checks++;
                if (load_ready !== en) begin
                    errors++; $display("FAIL load_ready got=%b exp=%b", load_ready, en);
                end
            end else begin
                load_valid = 1'b0;
            end
        end
        run_instr(mk(6'd0, 5'd4, 5'd1, 5'd2), 1'b1, dc);
        checks++;
        if (dc != 2 * WIDTH + 1) begin
            errors++; $display("FAIL load_vs_instr_latency got=%0d exp=%0d", dc, 2 * WIDTH + 1);
        end
    endtask

    task automatic test_back_to_back();
        int gap = -1;
        int seen = 0;
        @(negedge clk);
        instr = mk(6'd1, 5'd4, 5'd5, 5'd6); instr_valid = 1'b1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ready got=%b exp=1", instr_ready);
        end
        @(posedge clk);
        for (int c = 1; c <= 4 * WIDTH; c++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin
                gap = c;
                break;
            end
        end
        checks++;
        if (gap != 2 * WIDTH + 2) begin
            errors++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, 2 * WIDTH + 2);
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || addra !== ADDR_W'(5 * WIDTH) || first_bit !== 1'b1) begin
            errors++; $display("FAIL b2b_second_start got busy=%b addra=%0d fb=%b exp 1,%0d,1",
                               busy, addra, first_bit, 5 * WIDTH);
        end
        for (int c = 0; c < 4 * WIDTH; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL b2b_second_done got=%0d exp=1", seen);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_east();
        test_illegal();
        test_random();
        test_reset_mid();
        test_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
